// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS controller: state codes, opcode
// and funct values, ALU control codes and datapath mux select codes.
package mips_ctrl_pkg;

  // FSM state encodings
  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_RTWB   = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_JAL    = 4'd10;
  localparam logic [3:0] S_IEXEC  = 4'd11;
  localparam logic [3:0] S_IWB    = 4'd12;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type funct codes
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU control codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // reg_dst selects
  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  // mem_to_reg selects
  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  // alu_src_b selects
  localparam logic [1:0] ASB_B   = 2'b00;
  localparam logic [1:0] ASB_4   = 2'b01;
  localparam logic [1:0] ASB_IMM = 2'b10;
  localparam logic [1:0] ASB_BR  = 2'b11;

  // pc_source selects
  localparam logic [1:0] PCS_ALU = 2'b00;
  localparam logic [1:0] PCS_OUT = 2'b01;
  localparam logic [1:0] PCS_JMP = 2'b10;

  // Which ALU operation the current state asks for
  typedef enum logic [1:0] {
    CLS_ADD   = 2'd0,
    CLS_SUB   = 2'd1,
    CLS_OR    = 2'd2,
    CLS_FUNCT = 2'd3
  } alu_cls_e;

endpackage

// File: rtl/mips_alu_ctl.sv
// ALU control decode: fixed operations pass straight through, R-type
// operations are looked up from funct. Unknown funct yields AND (all zero)
// and raises funct_illegal.
import mips_ctrl_pkg::*;

module mips_alu_ctl (
  input  alu_cls_e   cls,
  input  logic [5:0] funct,
  output logic [2:0] alu_ctl,
  output logic       funct_illegal
);

  // class / funct to ALU code
  always_comb begin
    alu_ctl       = ALU_AND;
    funct_illegal = 1'b0;
    case (cls)
      CLS_ADD: alu_ctl = ALU_ADD;
      CLS_SUB: alu_ctl = ALU_SUB;
      CLS_OR:  alu_ctl = ALU_OR;
      default: begin
        case (funct)
          FN_ADD:  alu_ctl = ALU_ADD;
          FN_SUB:  alu_ctl = ALU_SUB;
          FN_AND:  alu_ctl = ALU_AND;
          FN_OR:   alu_ctl = ALU_OR;
          FN_SLT:  alu_ctl = ALU_SLT;
          default: funct_illegal = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mips_multi_ctrl.sv
// Multicycle MIPS control FSM. Moore decode of the state register drives the
// datapath selects and enables; pc_en (branch condition) and illegal are
// Mealy on zero/op/funct. Synchronous reset forces every output to zero.
import mips_ctrl_pkg::*;

module mips_multi_ctrl #(
  parameter int ST_W     = 4,
  parameter int ALUCTL_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          op,
  input  logic [5:0]          funct,
  input  logic                zero,
  output logic                pc_en,
  output logic                i_or_d,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic                ir_write,
  output logic                reg_write,
  output logic [1:0]          reg_dst,
  output logic [1:0]          mem_to_reg,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          pc_source,
  output logic                ext_zero,
  output logic [ALUCTL_W-1:0] alu_ctl,
  output logic                illegal,
  output logic [ST_W-1:0]     state
);

  logic [ST_W-1:0] state_q, state_d;
  alu_cls_e        alu_cls;
  logic            alu_used;
  logic [2:0]      alu_code;
  logic            funct_ill;
  logic            dec_ill;

  assign state = state_q;

  // state register; reset aborts any instruction back to FETCH
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // ALU operation class per state (kept apart from the main decode so the
  // funct lookup result can feed next-state without a false comb loop)
  always_comb begin
    alu_cls  = CLS_ADD;
    alu_used = 1'b0;
    case (state_q)
      S_FETCH, S_DECODE, S_MEMADR: alu_used = 1'b1;
      S_EXEC:   begin alu_cls = CLS_FUNCT; alu_used = 1'b1; end
      S_BRANCH: begin alu_cls = CLS_SUB;   alu_used = 1'b1; end
      S_IEXEC:  begin
        alu_cls  = (op == OP_ORI) ? CLS_OR : CLS_ADD;
        alu_used = 1'b1;
      end
      default: ;
    endcase
  end

  mips_alu_ctl u_alu_ctl (
    .cls           (alu_cls),
    .funct         (funct),
    .alu_ctl       (alu_code),
    .funct_illegal (funct_ill)
  );

  assign alu_ctl = (rst || !alu_used) ? '0 : ALUCTL_W'(alu_code);
  assign illegal = !rst && (dec_ill || (state_q == S_EXEC && funct_ill));

  // per-state output decode and next-state selection
  always_comb begin
    pc_en      = 1'b0;
    i_or_d     = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = RD_RT;
    mem_to_reg = M2R_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = ASB_B;
    pc_source  = PCS_ALU;
    ext_zero   = 1'b0;
    dec_ill    = 1'b0;
    state_d    = S_FETCH;
    case (state_q)
      S_FETCH: begin
        mem_rd    = 1'b1;
        ir_write  = 1'b1;
        pc_en     = 1'b1;
        alu_src_b = ASB_4;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = ASB_BR;
        case (op)
          OP_LW, OP_SW:    state_d = S_MEMADR;
          OP_RTYPE:        state_d = S_EXEC;
          OP_BEQ, OP_BNE:  state_d = S_BRANCH;
          OP_J:            state_d = S_JUMP;
          OP_JAL:          state_d = S_JAL;
          OP_ADDI, OP_ORI: state_d = S_IEXEC;
          default:         dec_ill = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = ASB_IMM;
        state_d   = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_rd  = 1'b1;
        i_or_d  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        reg_dst    = RD_RT;
        mem_to_reg = M2R_MDR;
      end
      S_MEMWR: begin
        mem_wr = 1'b1;
        i_or_d = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = ASB_B;
        state_d   = funct_ill ? S_FETCH : S_RTWB;
      end
      S_RTWB: begin
        reg_write = 1'b1;
        reg_dst   = RD_RD;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        pc_source = PCS_OUT;
        pc_en     = zero ^ (op == OP_BNE);
      end
      S_JUMP: begin
        pc_source = PCS_JMP;
        pc_en     = 1'b1;
      end
      S_JAL: begin
        // regfile and PC sample on the same edge, so $31 gets PC+4
        pc_source  = PCS_JMP;
        pc_en      = 1'b1;
        reg_write  = 1'b1;
        reg_dst    = RD_RA;
        mem_to_reg = M2R_PC;
      end
      S_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = ASB_IMM;
        ext_zero  = (op == OP_ORI);
        state_d   = S_IWB;
      end
      S_IWB: begin
        reg_write  = 1'b1;
        reg_dst    = RD_RT;
        mem_to_reg = M2R_ALU;
      end
      default: ;
    endcase
    if (rst) begin
      pc_en      = 1'b0;
      i_or_d     = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = RD_RT;
      mem_to_reg = M2R_ALU;
      alu_src_a  = 1'b0;
      alu_src_b  = ASB_B;
      pc_source  = PCS_ALU;
      ext_zero   = 1'b0;
      dec_ill    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_multi_ctrl.sv
// Randomized bench for mips_multi_ctrl. The reference model is a per
// instruction trace table: for each opcode it lists what every output should
// be on each cycle of that instruction.
module tb_mips_multi_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op, funct;
  logic       zero;
  logic       pc_en, i_or_d, mem_rd, mem_wr, ir_write, reg_write;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_source;
  logic       alu_src_a, ext_zero, illegal;
  logic [2:0] alu_ctl;
  logic [3:0] state;

  int errs = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  mips_multi_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
    .pc_en(pc_en), .i_or_d(i_or_d), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_source(pc_source), .ext_zero(ext_zero), .alu_ctl(alu_ctl),
    .illegal(illegal), .state(state)
  );

  // observed outputs in one vector, same field order as mk()
  wire [23:0] obs = {pc_en, i_or_d, mem_rd, mem_wr, ir_write, reg_write,
                     reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_source,
                     ext_zero, alu_ctl, illegal, state};

  task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] mk(
    input int st, input bit pcen, input bit iord, input bit rd, input bit wr,
    input bit irw, input bit rw, input int rdst, input int m2r, input bit asa,
    input int asb, input int psrc, input bit ez, input int alu, input bit ill);
    return {pcen, iord, rd, wr, irw, rw, 2'(rdst), 2'(m2r), asa, 2'(asb),
            2'(psrc), ez, 3'(alu), ill, 4'(st)};
  endfunction

  function automatic bit op_ok(input logic [5:0] o);
    return o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
                     6'b000010, 6'b000011, 6'b001000, 6'b001101};
  endfunction

  // ALU code for a funct, -1 when unsupported
  function automatic int fn_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 2;
      6'b100010: return 6;
      6'b100100: return 0;
      6'b100101: return 1;
      6'b101010: return 7;
      default:   return -1;
    endcase
  endfunction

  function automatic int ncyc(input logic [5:0] o, input logic [5:0] f);
    if (!op_ok(o)) return 2;
    case (o)
      6'b100011: return 5;
      6'b000000: return (fn_alu(f) < 0) ? 3 : 4;
      6'b000100, 6'b000101, 6'b000010, 6'b000011: return 3;
      default: return 4;
    endcase
  endfunction

  // expected outputs on cycle k of instruction (o,f) with the current zero
  function automatic logic [23:0] model(input logic [5:0] o, input logic [5:0] f,
                                        input int k, input bit z);
    int a;
    if (k == 0) return mk(0, 1,0,1,0,1,0, 0,0,0, 1,0,0, 2,0);
    if (k == 1) return mk(1, 0,0,0,0,0,0, 0,0,0, 3,0,0, 2, !op_ok(o));
    case (o)
      6'b100011, 6'b101011: begin
        if (k == 2) return mk(2, 0,0,0,0,0,0, 0,0,1, 2,0,0, 2,0);
        if (o == 6'b101011) return mk(5, 0,1,0,1,0,0, 0,0,0, 0,0,0, 0,0);
        if (k == 3) return mk(3, 0,1,1,0,0,0, 0,0,0, 0,0,0, 0,0);
        return mk(4, 0,0,0,0,0,1, 0,1,0, 0,0,0, 0,0);
      end
      6'b000000: begin
        a = fn_alu(f);
        if (k == 2) return mk(6, 0,0,0,0,0,0, 0,0,1, 0,0,0, (a < 0) ? 0 : a, a < 0);
        return mk(7, 0,0,0,0,0,1, 1,0,0, 0,0,0, 0,0);
      end
      6'b000100, 6'b000101:
        return mk(8, z ^ (o == 6'b000101), 0,0,0,0,0, 0,0,1, 0,1,0, 6,0);
      6'b000010: return mk(9, 1,0,0,0,0,0, 0,0,0, 0,2,0, 0,0);
      6'b000011: return mk(10, 1,0,0,0,0,1, 2,2,0, 0,2,0, 0,0);
      default: begin
        if (k == 2) return mk(11, 0,0,0,0,0,0, 0,0,1, 2,0, o == 6'b001101,
                              (o == 6'b001101) ? 1 : 2, 0);
        return mk(12, 0,0,0,0,0,1, 0,0,0, 0,0,0, 0,0);
      end
    endcase
  endfunction

  // called at posedge+1 with the DUT in FETCH; zsel 0/1 forces zero, 2 random
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zsel,
                           input string tag);
    int n;
    n = ncyc(o, f);
    op = o;
    funct = f;
    for (int k = 0; k < n; k++) begin
      zero = (zsel == 2) ? 1'($urandom) : 1'(zsel);
      #1;
      chk($sformatf("%s.c%0d", tag, k), obs, model(o, f, k, zero));
      @(posedge clk);
      #1;
    end
  endtask

  logic [5:0] ops [10];
  logic [5:0] fns [6];
  logic [5:0] ro, rf;

  initial begin
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
            6'b000010, 6'b000011, 6'b001000, 6'b001101, 6'b000000};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
    rst = 1'b1; op = 6'b100011; funct = '0; zero = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold", obs, 24'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_fetch", obs, mk(0, 1,0,1,0,1,0, 0,0,0, 1,0,0, 2,0));
    #1;  // realign to posedge+1 phase expected by run_instr (still in FETCH)
    @(posedge clk); // FETCH -> DECODE on the way; restart cleanly with reset
    rst = 1'b1; #1;
    @(posedge clk); #1;
    rst = 1'b0;

    run_instr(6'b100011, 6'b000000, 2, "lw");
    run_instr(6'b101011, 6'b000000, 2, "sw");
    run_instr(6'b000100, 6'b000000, 1, "beq_z1");
    run_instr(6'b000100, 6'b000000, 0, "beq_z0");
    run_instr(6'b000101, 6'b000000, 0, "bne_z0");
    run_instr(6'b000101, 6'b000000, 1, "bne_z1");
    run_instr(6'b000011, 6'b000000, 2, "jal");
    run_instr(6'b000010, 6'b000000, 2, "j");
    run_instr(6'b000000, 6'b100010, 2, "sub");
    run_instr(6'b000000, 6'b000111, 2, "bad_funct");
    run_instr(6'b111111, 6'b000000, 2, "bad_op");
    run_instr(6'b001101, 6'b000000, 2, "ori");
    run_instr(6'b001000, 6'b000000, 2, "addi");

    // reset mid-lw while in MEMRD: no MEMWB write afterwards
    op = 6'b100011;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1; #1;
    chk("rst_in_memrd", obs, mk(3, 0,0,0,0,0,0, 0,0,0, 0,0,0, 0,0));
    @(posedge clk); #1;
    rst = 1'b0; #1;
    chk("after_abort", obs, mk(0, 1,0,1,0,1,0, 0,0,0, 1,0,0, 2,0));

    // random instruction stream
    for (int i = 0; i < 80; i++) begin
      ro = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
      rf = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
      run_instr(ro, rf, 2, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule

// File: doc/mips_multi_ctrl.md
Name: mips_multi_ctrl

Overview:
Multicycle MIPS control FSM. It generates the select codes consumed by the datapath's mux_2_32, mux_3_32 and mux_3_5 instances, plus all write enables and the ALU control code. It sits beside the multicycle datapath, takes op/funct from the IR and zero from the ALU, and sequences each instruction through 3–5 states.

Parameters:
ST_W, 4, state register width
ALUCTL_W, 3, ALU control code width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
op  in  6  IR[31:26], stable from DECODE until next FETCH
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag, combinational from the datapath
pc_en  out  1  PC load enable (includes branch condition)
i_or_d  out  1  memory address select: 0 PC, 1 ALUOut
mem_rd  out  1  memory read
mem_wr  out  1  memory write
ir_write  out  1  IR load
reg_write  out  1  regfile write
reg_dst  out  2  mux_3_5 select: 00 rt, 01 rd, 10 5'd31
mem_to_reg  out  2  mux_3_32 select: 00 ALUOut, 01 MDR, 10 PC
alu_src_a  out  1  mux_2_32 select: 0 PC, 1 A
alu_src_b  out  2  00 B, 01 32'd4, 10 ext(imm), 11 sext(imm)<<2
pc_source  out  2  mux_3_32 select: 00 ALU result, 01 ALUOut, 10 jump target
ext_zero  out  1  immediate extension: 1 zero-extend, 0 sign-extend
alu_ctl  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
illegal  out  1  unsupported op/funct seen in the current cycle
state  out  4  current state, debug

Behaviour:
- Moore outputs decoded from the state register. pc_en and illegal are Mealy outputs on zero, op and funct.
- While rst=1, every enable (pc_en, mem_rd, mem_wr, ir_write, reg_write), ext_zero and illegal is forced to 0, and all selects are 0. The next state is FETCH(0).
- Every output not listed for a state is 0. "→" gives the next state.
- FETCH(0): mem_rd, ir_write, pc_en, alu_src_b=01, alu_ctl=ADD → DECODE.
- DECODE(1): alu_src_b=11, ADD; the branch target is latched into ALUOut. Dispatch on op:
  - lw (100011), sw (101011) → MEMADR
  - R-type (000000) → EXEC
  - beq (000100), bne (000101) → BRANCH
  - j (000010) → JUMP
  - jal (000011) → JAL
  - addi (001000), ori (001101) → IEXEC
  - any other op → illegal=1, then FETCH
- MEMADR(2): alu_src_a=1, alu_src_b=10, ADD → MEMRD for lw, MEMWR for sw.
- MEMRD(3): mem_rd, i_or_d=1 → MEMWB.
- MEMWB(4): reg_write, reg_dst=00, mem_to_reg=01 → FETCH.
- MEMWR(5): mem_wr, i_or_d=1 → FETCH.
- EXEC(6): alu_src_a=1, alu_src_b=00, alu_ctl decoded from funct:
  - add 100000 → ADD, sub 100010 → SUB, and 100100 → AND, or 100101 → OR, slt 101010 → SLT
  - supported funct → RTWB
  - any other funct → illegal=1, then FETCH with no write
- RTWB(7): reg_write, reg_dst=01 → FETCH.
- BRANCH(8): alu_src_a=1, SUB, pc_source=01, pc_en = zero XOR (op==bne) → FETCH.
- JUMP(9): pc_source=10, pc_en → FETCH.
- JAL(10): pc_source=10, pc_en, reg_write, reg_dst=10, mem_to_reg=10 → FETCH. The regfile and PC both sample on the same edge, so $31 receives the old PC, which is already PC+4.
- IEXEC(11): alu_src_a=1, alu_src_b=10. addi: ADD, ext_zero=0. ori: OR, ext_zero=1 → IWB.
- IWB(12): reg_write, reg_dst=00, mem_to_reg=00 → FETCH.
- Encodings 13–15 are unreachable. If entered, all outputs are 0 and the next state is FETCH.
- Cycle counts: lw 5; sw, R-type, addi, ori 4; beq, bne, j, jal 3.
- Codes 2'b11 are never emitted on reg_dst, mem_to_reg or pc_source.
- Reset asserted mid-instruction: the sync reset aborts at the next edge. No enable is high in the cycle where rst=1.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state encodings
  - opcode and funct constants
  - alu_ctl codes
  - select-code constants for reg_dst, mem_to_reg, alu_src_b and pc_source
- Sub-module mips_alu_ctl: combinational map from (class: ADD/SUB/OR/FUNCT, funct) to (alu_ctl, funct_illegal).

Test Plan:
- Reset: hold rst 2 cycles, then release → state=0, all enables 0 during rst. First post-reset cycle: mem_rd=1, ir_write=1, pc_en=1, alu_src_b=01.
- lw (op=100011) → states 0,1,2,3,4,0. MEMRD has i_or_d=1. MEMWB has reg_write=1, mem_to_reg=01, reg_dst=00.
- beq with zero=1 → BRANCH pc_en=1, pc_source=01. beq with zero=0 → pc_en=0. bne with zero=0 → pc_en=1. Each takes 3 cycles.
- jal → JAL state: pc_en=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=10.
- R-type sub (funct=100010) → EXEC alu_ctl=110, RTWB reg_dst=01. funct=000111 → illegal=1 in EXEC, next state FETCH, reg_write never high.
- op=111111 → illegal=1 in DECODE, next FETCH. ori → IEXEC ext_zero=1, alu_ctl=001. rst asserted during MEMRD → next state FETCH, no MEMWB write.
